// File: rtl/ts_cpu_bus_arb.sv
// ts_cpu_bus_arb
//   Two-requester round-robin arbiter and sequencer for the local CPU register bus.
//   A granted transaction runs SETUP (1) -> STROBE (STB_CYCLES) -> HOLD (1) -> RESP (1),
//   then the arbiter returns to IDLE. Read data is sampled from the shared slave bus
//   in the last strobe cycle and returned on a one-cycle response pulse.
//
// Ports
//   clks, reset              clock, synchronous active-high reset
//   reqN_vld/rdy             request handshake (vld & rdy = transfer), N = 0, 1
//   reqN_wr/addr/wdata       request attributes, sampled on transfer
//   rspN_vld/rdata           completion pulse; rdata is 0 for writes
//   cpu_addr, cpu_data_in    bus address and write data (hold last value)
//   cpu_rd, cpu_wr           read/write strobes, only in STROBE
//   cpu_rd_dly1              cpu_rd delayed one cycle (slaves latch on its fall)
//   cpu_data_out             combined read data from slaves
module ts_cpu_bus_arb #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned STB_CYCLES = 4
) (
    input  logic                  clks,
    input  logic                  reset,
    input  logic                  req0_vld,
    output logic                  req0_rdy,
    input  logic                  req0_wr,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [31:0]           req0_wdata,
    output logic                  rsp0_vld,
    output logic [31:0]           rsp0_rdata,
    input  logic                  req1_vld,
    output logic                  req1_rdy,
    input  logic                  req1_wr,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [31:0]           req1_wdata,
    output logic                  rsp1_vld,
    output logic [31:0]           rsp1_rdata,
    output logic [ADDR_WIDTH-1:0] cpu_addr,
    output logic                  cpu_rd,
    output logic                  cpu_rd_dly1,
    output logic                  cpu_wr,
    output logic [31:0]           cpu_data_in,
    input  logic [31:0]           cpu_data_out
);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold,
        StResp
    } state_e;

    localparam logic [3:0] StbLast = 4'(STB_CYCLES - 1);

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic                  owner_q, owner_d;
    // Requester granted most recently; 1 at reset so requester 0 wins the first tie.
    logic                  last_q, last_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  rd_dly_q;
    logic                  grant0, grant1;
    logic                  in_strobe, in_resp;

    assign grant0 = req0_vld & (~req1_vld | last_q);
    assign grant1 = req1_vld & (~req0_vld | ~last_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        owner_d  = owner_q;
        last_d   = last_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        req0_rdy = 1'b0;
        req1_rdy = 1'b0;
        case (state_q)
            StIdle: begin
                req0_rdy = grant0;
                req1_rdy = grant1;
                if (grant0 | grant1) begin
                    state_d = StSetup;
                    owner_d = grant1;
                    last_d  = grant1;
                    wr_d    = grant1 ? req1_wr    : req0_wr;
                    addr_d  = grant1 ? req1_addr  : req0_addr;
                    wdata_d = grant1 ? req1_wdata : req0_wdata;
                end
            end
            StSetup: begin
                state_d = StStrobe;
                cnt_d   = '0;
            end
            StStrobe: begin
                if (cnt_q == StbLast) begin
                    state_d = StHold;
                    // Sample read data at the end of the strobe, before slaves release it.
                    if (!wr_q) begin
                        rdata_d = cpu_data_out;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StHold: begin
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clks) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rd_dly_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rd_dly_q <= cpu_rd;
        end
    end

    assign in_strobe   = (state_q == StStrobe);
    assign in_resp     = (state_q == StResp);

    assign cpu_rd      = in_strobe & ~wr_q;
    assign cpu_wr      = in_strobe & wr_q;
    assign cpu_rd_dly1 = rd_dly_q;
    assign cpu_addr    = addr_q;
    assign cpu_data_in = wdata_q;

    assign rsp0_vld    = in_resp & ~owner_q;
    assign rsp1_vld    = in_resp & owner_q;
    assign rsp0_rdata  = (rsp0_vld & ~wr_q) ? rdata_q : 32'h0;
    assign rsp1_rdata  = (rsp1_vld & ~wr_q) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_ts_cpu_bus_arb.sv
// Bench for ts_cpu_bus_arb: instance "a" with STB_CYCLES=4, instance "b" with STB_CYCLES=1.
module tb_ts_cpu_bus_arb;

    localparam int          STB       = 4;
    localparam logic [15:0] TEST_ADDR = 16'h00F0;

    logic clks = 1'b0;
    logic reset = 1'b1;
    always #5 clks = ~clks;

    int cyc = 0;
    always @(posedge clks) cyc <= cyc + 1;

    // Instance a
    logic        req0_vld, req0_rdy, req0_wr, rsp0_vld;
    logic [15:0] req0_addr;
    logic [31:0] req0_wdata, rsp0_rdata;
    logic        req1_vld, req1_rdy, req1_wr, rsp1_vld;
    logic [15:0] req1_addr;
    logic [31:0] req1_wdata, rsp1_rdata;
    logic [15:0] cpu_addr;
    logic        cpu_rd, cpu_rd_dly1, cpu_wr;
    logic [31:0] cpu_data_in, cpu_data_out;

    // Instance b (requester 1 tied off)
    logic        b_vld, b_rdy, b_rsp_vld, b_req1_rdy, b_rsp1_vld;
    logic [15:0] b_addr, b_cpu_addr;
    logic [31:0] b_rsp_rdata, b_rsp1_rdata, b_cpu_data_in, b_cpu_data_out;
    logic        b_cpu_rd, b_cpu_rd_dly1, b_cpu_wr;

    ts_cpu_bus_arb #(.ADDR_WIDTH(16), .STB_CYCLES(STB)) dut_a (
        .clks(clks), .reset(reset),
        .req0_vld(req0_vld), .req0_rdy(req0_rdy), .req0_wr(req0_wr),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_vld(rsp0_vld), .rsp0_rdata(rsp0_rdata),
        .req1_vld(req1_vld), .req1_rdy(req1_rdy), .req1_wr(req1_wr),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_vld(rsp1_vld), .rsp1_rdata(rsp1_rdata),
        .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_rd_dly1(cpu_rd_dly1), .cpu_wr(cpu_wr),
        .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out)
    );

    ts_cpu_bus_arb #(.ADDR_WIDTH(16), .STB_CYCLES(1)) dut_b (
        .clks(clks), .reset(reset),
        .req0_vld(b_vld), .req0_rdy(b_rdy), .req0_wr(1'b0),
        .req0_addr(b_addr), .req0_wdata(32'h0),
        .rsp0_vld(b_rsp_vld), .rsp0_rdata(b_rsp_rdata),
        .req1_vld(1'b0), .req1_rdy(b_req1_rdy), .req1_wr(1'b0),
        .req1_addr(16'h0), .req1_wdata(32'h0),
        .rsp1_vld(b_rsp1_vld), .rsp1_rdata(b_rsp1_rdata),
        .cpu_addr(b_cpu_addr), .cpu_rd(b_cpu_rd), .cpu_rd_dly1(b_cpu_rd_dly1),
        .cpu_wr(b_cpu_wr), .cpu_data_in(b_cpu_data_in), .cpu_data_out(b_cpu_data_out)
    );

    // Slave model: fixed data at 0x0010, a test register that latches ~addr on the
    // falling edge of a read, and {C0DE, addr} elsewhere.
    logic [31:0] test_reg = 32'h0;

    function automatic logic [31:0] slave_val(input logic [15:0] a, input logic [31:0] tr);
        if (a == TEST_ADDR) return tr;
        if (a == 16'h0010) return 32'h1234_5678;
        return {16'hC0DE, a};
    endfunction

    assign cpu_data_out   = cpu_rd ? slave_val(cpu_addr, test_reg) : 32'h0;
    assign b_cpu_data_out = b_cpu_rd ? {16'hB000, b_cpu_addr} : 32'h0;

    always @(posedge clks) begin
        if (cpu_rd_dly1 && !cpu_rd) test_reg <= {~cpu_addr, ~cpu_addr};
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, want);
        end
    endtask

    task automatic fail_event(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s at cycle %0d: actual=%s required=none", name, cyc, what);
    endtask

    // Scoreboard queues
    logic [31:0] exp0_q[$];
    logic [31:0] exp1_q[$];
    bit          grant_q[$];
    int          xfer_times[$];
    logic [31:0] b_exp_q[$];
    int          b_due_q[$];
    int          b_times[$];

    // Cycle model of instance a: strobe shape, address hold, handshakes, rsp timing.
    bit          rst_pending  = 1'b1;
    bit          xfer_pending = 1'b0;
    bit          cur_valid    = 1'b0;
    bit          cur_wr       = 1'b0;
    bit          cur_owner    = 1'b0;
    bit          last_owner   = 1'b1;
    int          cur_t        = 0;
    logic [15:0] cur_addr     = '0;
    logic [15:0] exp_addr     = '0;
    logic [31:0] cur_wdata    = '0;
    logic [31:0] exp_din      = '0;

    initial begin : model_a
        bit busy, e_rd, e_wr, e_dly, e_r0, e_r1, e_rdy0, e_rdy1;
        int d;
        forever begin
            @(negedge clks);
            if (rst_pending) begin
                cur_valid    = 1'b0;
                last_owner   = 1'b1;
                exp_addr     = '0;
                exp_din      = '0;
                xfer_pending = 1'b0;
            end else if (xfer_pending) begin
                exp_addr     = cur_addr;
                exp_din      = cur_wdata;
                xfer_pending = 1'b0;
            end
            d      = cyc - cur_t;
            busy   = cur_valid && d >= 1 && d <= STB + 3;
            e_rd   = cur_valid && !cur_wr && d >= 2 && d <= STB + 1;
            e_wr   = cur_valid && cur_wr && d >= 2 && d <= STB + 1;
            e_dly  = cur_valid && !cur_wr && d >= 3 && d <= STB + 2;
            e_r0   = cur_valid && d == STB + 3 && !cur_owner;
            e_r1   = cur_valid && d == STB + 3 && cur_owner;
            e_rdy0 = !busy && req0_vld && (!req1_vld || last_owner);
            e_rdy1 = !busy && req1_vld && (!req0_vld || !last_owner);
            check("cpu_rd", 32'(cpu_rd), 32'(e_rd));
            check("cpu_wr", 32'(cpu_wr), 32'(e_wr));
            check("cpu_rd_dly1", 32'(cpu_rd_dly1), 32'(e_dly));
            check("cpu_addr", 32'(cpu_addr), 32'(exp_addr));
            check("cpu_data_in", cpu_data_in, exp_din);
            check("rsp0_vld", 32'(rsp0_vld), 32'(e_r0));
            check("rsp1_vld", 32'(rsp1_vld), 32'(e_r1));
            check("req0_rdy", 32'(req0_rdy), 32'(e_rdy0));
            check("req1_rdy", 32'(req1_rdy), 32'(e_rdy1));
            if (!reset && ((req0_vld && req0_rdy) || (req1_vld && req1_rdy))) begin
                cur_owner    = req1_vld && req1_rdy;
                cur_wr       = cur_owner ? req1_wr : req0_wr;
                cur_addr     = cur_owner ? req1_addr : req0_addr;
                cur_wdata    = cur_owner ? req1_wdata : req0_wdata;
                cur_t        = cyc;
                cur_valid    = 1'b1;
                xfer_pending = 1'b1;
                last_owner   = cur_owner;
                xfer_times.push_back(cyc);
                if (grant_q.size() == 0) fail_event("grant_owner", "unexpected transfer");
                else check("grant_owner", 32'(cur_owner), 32'(grant_q.pop_front()));
            end
            rst_pending = reset;
        end
    end

    // Response monitor for instance a
    initial begin : mon_rsp_a
        forever begin
            @(negedge clks);
            if (rsp0_vld) begin
                if (exp0_q.size() == 0) fail_event("rsp0_rdata", "unexpected rsp0");
                else check("rsp0_rdata", rsp0_rdata, exp0_q.pop_front());
            end
            if (rsp1_vld) begin
                if (exp1_q.size() == 0) fail_event("rsp1_rdata", "unexpected rsp1");
                else check("rsp1_rdata", rsp1_rdata, exp1_q.pop_front());
            end
        end
    end

    // Monitor for instance b: latency STB_CYCLES+3 = 4
    initial begin : mon_b
        forever begin
            @(negedge clks);
            if (b_rsp_vld) begin
                if (b_exp_q.size() == 0 || b_due_q.size() == 0) begin
                    fail_event("b_rsp", "unexpected rsp");
                end else begin
                    check("b_rsp_rdata", b_rsp_rdata, b_exp_q.pop_front());
                    check("b_rsp_cycle", cyc, b_due_q.pop_front());
                end
            end
            if (!reset && b_vld && b_rdy) begin
                b_times.push_back(cyc);
                b_due_q.push_back(cyc + 4);
            end
        end
    end

    task automatic do_req(input bit port, input bit wr, input logic [15:0] addr,
                          input logic [31:0] wdata, input logic [31:0] want, input bit expect_rsp);
        bit ok = 1'b0;
        if (expect_rsp) begin
            if (port) exp1_q.push_back(want);
            else exp0_q.push_back(want);
        end
        grant_q.push_back(port);
        if (port) begin
            req1_wr = wr; req1_addr = addr; req1_wdata = wdata; req1_vld = 1'b1;
        end else begin
            req0_wr = wr; req0_addr = addr; req0_wdata = wdata; req0_vld = 1'b1;
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clks);
            if (port ? req1_rdy : req0_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_event("req_accept", "timeout");
        @(posedge clks);
        #1;
        if (port) req1_vld = 1'b0;
        else req0_vld = 1'b0;
    endtask

    task automatic b_req(input logic [15:0] addr);
        bit ok = 1'b0;
        b_exp_q.push_back({16'hB000, addr});
        b_addr = addr;
        b_vld  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clks);
            if (b_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_event("b_req_accept", "timeout");
        @(posedge clks);
        #1;
        b_vld = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clks);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog at cycle %0d: actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        req0_vld = 1'b0; req0_wr = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_vld = 1'b0; req1_wr = 1'b0; req1_addr = '0; req1_wdata = '0;
        b_vld = 1'b0; b_addr = '0;

        // Both requesters valid from reset and held: grants 0,1,0,1, 8 cycles apart.
        req0_addr = 16'h0040; req1_addr = 16'h0050;
        req0_vld  = 1'b1;     req1_vld  = 1'b1;
        grant_q.push_back(1'b0); grant_q.push_back(1'b1);
        grant_q.push_back(1'b0); grant_q.push_back(1'b1);
        exp0_q.push_back(32'hC0DE_0040); exp0_q.push_back(32'hC0DE_0040);
        exp1_q.push_back(32'hC0DE_0050); exp1_q.push_back(32'hC0DE_0050);
        repeat (3) @(posedge clks);
        #1 reset = 1'b0;
        n = 0;
        for (int i = 0; i < 100 && n < 4; i++) begin
            @(negedge clks);
            if ((req0_vld && req0_rdy) || (req1_vld && req1_rdy)) n++;
        end
        if (n < 4) fail_event("held_grants", "timeout");
        @(posedge clks);
        #1 req0_vld = 1'b0; req1_vld = 1'b0;
        idle_cycles(10);
        for (int i = 0; i < 3; i++) check("held_spacing", xfer_times[i + 1] - xfer_times[i], 8);

        // Write from requester 1: rdata 0, no read strobes.
        do_req(1'b1, 1'b1, 16'h0020, 32'hA5A5_0F0F, 32'h0, 1'b1);
        idle_cycles(10);

        // Read 0x0010, then the test register holds ~0x0010 duplicated.
        do_req(1'b0, 1'b0, 16'h0010, 32'h0, 32'h1234_5678, 1'b1);
        idle_cycles(10);
        do_req(1'b0, 1'b0, TEST_ADDR, 32'h0, 32'hFFEF_FFEF, 1'b1);
        idle_cycles(10);

        // Reset in the 2nd strobe cycle of a read: aborted, test register untouched.
        do_req(1'b0, 1'b0, 16'h0030, 32'h0, 32'h0, 1'b0);
        idle_cycles(2);
        reset = 1'b1;
        idle_cycles(1);
        reset = 1'b0;
        idle_cycles(3);
        do_req(1'b0, 1'b0, TEST_ADDR, 32'h0, 32'hFF0F_FF0F, 1'b1);
        idle_cycles(10);

        // STB_CYCLES=1 instance: back-to-back reads 5 cycles apart, rsp at t+4.
        b_req(16'h0060);
        b_req(16'h0070);
        idle_cycles(10);
        check("b_spacing", b_times.size() >= 2 ? b_times[1] - b_times[0] : 0, 5);

        check("exp0_drained", exp0_q.size(), 0);
        check("exp1_drained", exp1_q.size(), 0);
        check("grant_drained", grant_q.size(), 0);
        check("b_drained", b_exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
